// File: rtl/up_down_counter_param.sv
// Parametrised up/down counter with programmable modulus, clear/load/enable,
// wrap or saturate at the bounds, boundary flags and registered event pulses.
module up_down_counter_param #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
    parameter bit               SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             mode,
    output logic [WIDTH-1:0] q,
    output logic             at_max,
    output logic             at_min,
    output logic             ovf,
    output logic             unf,
    output logic             bound_sticky
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             sticky_q, sticky_d;
    logic [WIDTH-1:0] load_clamped;

    assign load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;

    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_d    = cnt_q;
        ovf_d    = 1'b0;
        unf_d    = 1'b0;
        sticky_d = sticky_q;
        if (clr) begin
            cnt_d    = '0;
            sticky_d = 1'b0;
        end else if (load) begin
            cnt_d = load_clamped;
        end else if (en) begin
            if (mode) begin
                if (cnt_q == MAX_VAL) begin
                    cnt_d    = SATURATE ? MAX_VAL : '0;
                    ovf_d    = 1'b1;
                    sticky_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + WIDTH'(1);
                end
            end else begin
                if (cnt_q == '0) begin
                    cnt_d    = SATURATE ? '0 : MAX_VAL;
                    unf_d    = 1'b1;
                    sticky_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - WIDTH'(1);
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update together on the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            sticky_q <= sticky_d;
        end
    end

    assign q            = cnt_q;
    assign at_max       = (cnt_q == MAX_VAL);
    assign at_min       = (cnt_q == '0);
    assign ovf          = ovf_q;
    assign unf          = unf_q;
    assign bound_sticky = sticky_q;

endmodule
